// File: rtl/cfs_apb_pkg.sv
// Shared types and limits for the CFS APB register slave.
// Holds the transfer FSM state encoding and the parameter ceilings.
package cfs_apb_pkg;

    localparam int unsigned CFS_APB_MAX_ADDR_WIDTH = 16;
    localparam int unsigned CFS_APB_MAX_DATA_WIDTH = 32;

    // Width of the wait-state counter; covers WAIT_STATES up to 15.
    localparam int unsigned CFS_APB_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } cfs_apb_state_t;

endpackage

// File: rtl/cfs_apb_reg_file.sv
// Register storage for the CFS APB slave: byte-strobed writes and
// a one-cycle write pulse per register, both registered on clk.
module cfs_apb_reg_file
    import cfs_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REGS-1:0]            reg_we,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            // Pulse follows the enable even when no strobe bit is set.
            wr_pulse <= reg_we;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (reg_we[i] && wstrb[b]) begin
                        regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: rtl/cfs_apb_reg_slave.sv
// APB slave exposing NUM_REGS word registers with optional wait states.
// Define CFS_APB_PSTRB_EN to add the pstrb port and byte-granular writes.
module cfs_apb_reg_slave
    import cfs_apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
`ifdef CFS_APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
`endif
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    cfs_apb_state_t              state;
    cfs_apb_state_t              state_nxt;
    logic [CFS_APB_WAIT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]            idx;
    logic                        addr_err;
    logic [DATA_WIDTH-1:0]       rd_word;
    logic [NUM_REGS-1:0]         reg_we;
    logic [STRB_W-1:0]           wstrb;
    logic                        paddr_lsb_unused;

    assign idx              = paddr[ADDR_WIDTH-1:2];
    assign addr_err         = 32'(idx) >= 32'(NUM_REGS);
    assign paddr_lsb_unused = ^paddr[1:0];

`ifdef CFS_APB_PSTRB_EN
    assign wstrb = pstrb;
`else
    assign wstrb = '1;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (psel && !penable) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (!psel || pready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (state == ACCESS && wait_cnt == '0 && psel && penable) begin
            pready  = 1'b1;
            pslverr = addr_err;
            if (!pwrite && !addr_err) begin
                prdata = rd_word;
            end
        end
    end

    // Counter is reloaded on every SETUP, so an abandoned access needs no cleanup.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= CFS_APB_WAIT_W'(WAIT_STATES);
        end else if (state == ACCESS && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CFS_APB_WAIT_W'(1);
        end
    end

    always_comb begin
        rd_word = '0;
        reg_we  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) begin
                rd_word   = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
                reg_we[i] = pready && pwrite && !addr_err;
            end
        end
    end

    cfs_apb_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_file (
        .clk      (pclk),
        .rst      (preset),
        .reg_we   (reg_we),
        .wdata    (pwdata),
        .wstrb    (wstrb),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_cfs_apb_reg_slave.sv
// Directed bench for cfs_apb_reg_slave: four instances with WAIT_STATES 0/2/3/5,
// a register model and a queue of expected completions per transfer.
module tb_cfs_apb_reg_slave;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 8;
`ifdef CFS_APB_PSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             preset   [N];
    logic             psel     [N];
    logic             penable  [N];
    logic             pwrite   [N];
    logic [AW-1:0]    paddr    [N];
    logic [DW-1:0]    pwdata   [N];
    logic [DW/8-1:0]  pstrb    [N];
    logic             pready   [N];
    logic             pslverr  [N];
    logic [DW-1:0]    prdata   [N];
    logic [NR*DW-1:0] reg_q    [N];
    logic [NR-1:0]    wr_pulse [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        cfs_apb_reg_slave #(
            .ADDR_WIDTH  (AW),
            .DATA_WIDTH  (DW),
            .NUM_REGS    (NR),
            .WAIT_STATES (g == 0 ? 0 : g == 1 ? 2 : g == 2 ? 3 : 5)
        ) u_dut (
            .pclk     (clk),
            .preset   (preset[g]),
            .psel     (psel[g]),
            .penable  (penable[g]),
            .pwrite   (pwrite[g]),
            .paddr    (paddr[g]),
            .pwdata   (pwdata[g]),
`ifdef CFS_APB_PSTRB_EN
            .pstrb    (pstrb[g]),
`endif
            .pready   (pready[g]),
            .prdata   (prdata[g]),
            .pslverr  (pslverr[g]),
            .reg_q    (reg_q[g]),
            .wr_pulse (wr_pulse[g])
        );
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        logic [NR-1:0] pulse;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] mdl [N][NR];
    int            n_chk  = 0;
    int            n_fail = 0;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic [NR*DW-1:0] mdl_pack(input int d);
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = mdl[d][i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is #1 after a rising edge; returns after the negedge of the cycle after completion.
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input string tag);
        exp_t            e;
        exp_t            got;
        int              idx;
        int              n;
        logic [DW/8-1:0] eff;
        idx     = int'(addr[AW-1:2]);
        e.err   = (idx >= NR);
        e.lat   = ws_of(d) + 1;
        e.rdata = (!wr && !e.err) ? mdl[d][idx] : '0;
        e.pulse = (wr && !e.err) ? (NR'(1) << idx) : '0;
        sb.push_back(e);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        n = 0;
        got.lat = -1; got.rdata = 'x; got.err = 1'bx;
        while (got.lat < 0 && n <= 40) begin
            @(negedge clk);
            if (pready[d] === 1'b1) begin
                got.lat = n; got.rdata = prdata[d]; got.err = pslverr[d];
            end else begin
                chk({tag, " wait_prdata"}, prdata[d], '0);
                chk({tag, " wait_pslverr"}, pslverr[d], '0);
                @(posedge clk); #1;
                n++;
            end
        end
        e = sb.pop_front();
        chk({tag, " latency"}, got.lat, e.lat);
        chk({tag, " prdata"}, got.rdata, e.rdata);
        chk({tag, " pslverr"}, got.err, e.err);
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        eff = STRB_EN ? pstrb[d] : '1;
        if (wr && !e.err) begin
            for (int b = 0; b < DW/8; b++) if (eff[b]) mdl[d][idx][b*8 +: 8] = data[b*8 +: 8];
        end
        @(negedge clk);
        chk({tag, " wr_pulse"}, wr_pulse[d], e.pulse);
        chk({tag, " reg_q"}, reg_q[d], mdl_pack(d));
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < N; d++) begin
            preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '1;
            for (int i = 0; i < NR; i++) mdl[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) preset[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("rst_pready%0d", d), pready[d], '0);
            chk($sformatf("rst_pslverr%0d", d), pslverr[d], '0);
            chk($sformatf("rst_prdata%0d", d), prdata[d], '0);
            chk($sformatf("rst_reg_q%0d", d), reg_q[d], '0);
            chk($sformatf("rst_wr_pulse%0d", d), wr_pulse[d], '0);
        end

        // WAIT_STATES=0: basic write/read, single-cycle pulse, errors, back-to-back
        step();
        xfer(0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, "w_r1");
        step();
        @(negedge clk);
        chk("pulse_once", wr_pulse[0], '0);
        chk("r1_value", reg_q[0][1*DW +: DW], 32'hDEADBEEF);
        step();
        xfer(0, 1'b0, 16'h0004, 32'h0, 4'hF, "r_r1");
        step();
        xfer(0, 1'b1, 16'h0020, 32'h12345678, 4'hF, "w_err_idx8");
        step();
        xfer(0, 1'b0, 16'hFFFC, 32'h0, 4'hF, "r_err_top");
        step();
        xfer(0, 1'b1, 16'h001C, 32'hCAFEF00D, 4'hF, "w_r7");
        xfer(0, 1'b0, 16'h001C, 32'h0, 4'hF, "r_r7_b2b");
        xfer(0, 1'b1, 16'h0003, 32'h0BADC0DE, 4'hF, "w_r0_lsb_b2b");
        xfer(0, 1'b0, 16'h0000, 32'h0, 4'hF, "r_r0_b2b");

        // penable without a setup phase must not start a transfer
        step();
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 16'h0008; pwdata[0] = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_penable_pready", pready[0], '0);
            step();
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        chk("idle_penable_reg_q", reg_q[0], mdl_pack(0));
        step();
        xfer(0, 1'b0, 16'h001C, 32'h0, 4'hF, "r_r7_after_viol");

        // byte strobes (full-word update when the strobe port is absent)
        step();
        xfer(0, 1'b1, 16'h0008, 32'h11223344, 4'hF, "w_r2_init");
        xfer(0, 1'b1, 16'h0008, 32'hAABBCCDD, 4'b0101, "w_r2_strb");
        chk("r2_strb_value", reg_q[0][2*DW +: DW], STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD);
        xfer(0, 1'b1, 16'h0008, 32'h55667788, 4'b0000, "w_r2_nostrb");
        xfer(0, 1'b0, 16'h0008, 32'h0, 4'hF, "r_r2");

        // WAIT_STATES=3: four-cycle read latency
        step();
        xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, "ws3_r0_zero");
        xfer(2, 1'b1, 16'h0000, 32'h5A5AA5A5, 4'hF, "ws3_w0");
        xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, "ws3_r0");

        // WAIT_STATES=2: psel dropped in the access wait cycle abandons the write
        step();
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h0004; pwdata[1] = 32'h77777777;
        step();
        penable[1] = 1'b1;
        @(negedge clk);
        chk("abort_setup_pready", pready[1], '0);
        step();
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        chk("abort_access_pready", pready[1], '0);
        chk("abort_access_pslverr", pslverr[1], '0);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("abort_pready", pready[1], '0);
            chk("abort_wr_pulse", wr_pulse[1], '0);
            chk("abort_reg_q", reg_q[1], mdl_pack(1));
        end
        step();
        xfer(1, 1'b1, 16'h0004, 32'h13579BDF, 4'hF, "ws2_w1_after_abort");
        xfer(1, 1'b0, 16'h0004, 32'h0, 4'hF, "ws2_r1");

        // WAIT_STATES=5: reset on the second access cycle of a write
        step();
        psel[3] = 1'b1; penable[3] = 1'b0; pwrite[3] = 1'b1; paddr[3] = 16'h0008; pwdata[3] = 32'h99999999;
        step();
        penable[3] = 1'b1;
        step();
        step();
        preset[3] = 1'b1;
        @(negedge clk);
        chk("rst_mid_pready_before", pready[3], '0);
        step();
        preset[3] = 1'b0;
        @(negedge clk);
        chk("rst_mid_pready", pready[3], '0);
        chk("rst_mid_pslverr", pslverr[3], '0);
        chk("rst_mid_prdata", prdata[3], '0);
        chk("rst_mid_reg_q", reg_q[3], '0);
        chk("rst_mid_wr_pulse", wr_pulse[3], '0);
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            chk("rst_mid_idle_pready", pready[3], '0);
            chk("rst_mid_idle_reg2", reg_q[3][2*DW +: DW], '0);
        end
        step();
        psel[3] = 1'b0; penable[3] = 1'b0;
        step();
        xfer(3, 1'b0, 16'h0008, 32'h0, 4'hF, "ws5_r2_zero");
        xfer(3, 1'b1, 16'h0008, 32'h24681357, 4'hF, "ws5_w2");
        xfer(3, 1'b0, 16'h0008, 32'h0, 4'hF, "ws5_r2");

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
